otp_fuse_prog_ctrl: RTL and testbench

Word-granular programming controller for the OTP fuse macro. It sits directly upstream of the fuse shadow and protection checks. At reset exit it loads a shadow copy of all fuse words from the macro. It then serves programming requests, gating each one on lifecycle state and prior programming, and issues a timed program pulse with readback verify and bounded retry. It drives fuse_value, word_programmed and program_accepted, which the OTP protection assertions consume.

---
 rtl/otp_fuse_prog_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_otp_fuse_prog_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_fuse_prog_ctrl.sv
// Word-granular OTP fuse programming controller: shadow load at reset exit, then
// gated program pulses with readback verify and bounded retry.
module otp_fuse_prog_ctrl #(
    parameter int FUSE_WIDTH   = 256,
    parameter int WORD_WIDTH   = 32,
    parameter int PULSE_CYCLES = 100,
    parameter int MAX_RETRY    = 2,
    localparam int NWORDS      = FUSE_WIDTH / WORD_WIDTH,
    localparam int AW          = $clog2(NWORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_req,
    output logic                  prog_ready,
    input  logic [AW-1:0]         prog_addr,
    input  logic [WORD_WIDTH-1:0] prog_data,
    input  logic                  lifecycle_allows,
    output logic                  prog_done,
    output logic [2:0]            prog_status,
    output logic                  program_accepted,
    output logic                  init_done,
    output logic [FUSE_WIDTH-1:0] fuse_value,
    output logic [NWORDS-1:0]     word_programmed,
    output logic                  otp_pgm_en,
    output logic [AW-1:0]         otp_addr,
    output logic [WORD_WIDTH-1:0] otp_wdata,
    output logic                  otp_rd_en,
    input  logic [WORD_WIDTH-1:0] otp_rdata,
    input  logic                  otp_rd_valid
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_ERR_LC     = 3'd1;
    localparam logic [2:0] ST_ERR_REPROG = 3'd2;
    localparam logic [2:0] ST_ERR_ZERO   = 3'd3;
    localparam logic [2:0] ST_ERR_VERIFY = 3'd4;

    typedef enum logic [3:0] {
        INIT_RD,
        INIT_WAIT,
        IDLE,
        CHECK,
        PROGRAM,
        VERIFY_RD,
        VERIFY_WAIT,
        COMMIT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    started_q, started_d;
    logic [AW-1:0]           init_idx_q, init_idx_d;
    logic                    init_done_q, init_done_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic                    lc_q, lc_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic [CW-1:0]           pulse_cnt_q, pulse_cnt_d;
    logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
    logic [2:0]              result_q, result_d;
    logic [2:0]              status_q, status_d;
    logic [FUSE_WIDTH-1:0]   fuse_q, fuse_d;
    logic [NWORDS-1:0]       wp_q, wp_d;

    // Single shadow write port shared by the init load and COMMIT.
    logic                    wr_en;
    logic [AW-1:0]           wr_idx;
    logic [WORD_WIDTH-1:0]   wr_word;
    logic                    wr_flag;
    logic [NWORDS-1:0]       word_sel;

    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        addr_d      = addr_q;
        data_d      = data_q;
        lc_d        = lc_q;
        retry_d     = retry_q;
        pulse_cnt_d = pulse_cnt_q;
        rdata_d     = rdata_q;
        result_d    = result_q;
        status_d    = status_q;
        wr_en       = 1'b0;
        wr_idx      = init_idx_q;
        wr_word     = otp_rdata;
        wr_flag     = 1'b0;

        case (state_q)
            // Hold off the first read until one clean edge after reset release.
            INIT_RD: begin
                if (started_q) begin
                    state_d = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (otp_rd_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = init_idx_q;
                    wr_word = otp_rdata;
                    wr_flag = (otp_rdata != '0);
                    if (init_idx_q == AW'(NWORDS - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        init_idx_d = init_idx_q + AW'(1);
                        state_d    = INIT_RD;
                    end
                end
            end
            IDLE: begin
                if (prog_req && init_done_q) begin
                    addr_d  = prog_addr;
                    data_d  = prog_data;
                    lc_d    = lifecycle_allows;
                    retry_d = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                pulse_cnt_d = '0;
                if (!lc_q) begin
                    status_d = ST_ERR_LC;
                    state_d  = DONE;
                end else if (wp_q[addr_q]) begin
                    status_d = ST_ERR_REPROG;
                    state_d  = DONE;
                end else if (data_q == '0) begin
                    status_d = ST_ERR_ZERO;
                    state_d  = DONE;
                end else begin
                    state_d = PROGRAM;
                end
            end
            PROGRAM: begin
                if (pulse_cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    pulse_cnt_d = '0;
                    state_d     = VERIFY_RD;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + CW'(1);
                end
            end
            VERIFY_RD: begin
                state_d = VERIFY_WAIT;
            end
            VERIFY_WAIT: begin
                if (otp_rd_valid) begin
                    rdata_d = otp_rdata;
                    if (otp_rdata == data_q) begin
                        result_d = ST_OK;
                        state_d  = COMMIT;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = PROGRAM;
                    end else begin
                        result_d = ST_ERR_VERIFY;
                        state_d  = COMMIT;
                    end
                end
            end
            // Shadow takes the readback, and the word is marked non-blank even on a
            // failed verify since some bits may already be blown.
            COMMIT: begin
                wr_en    = 1'b1;
                wr_idx   = addr_q;
                wr_word  = rdata_q;
                wr_flag  = 1'b1;
                status_d = result_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT_RD;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word_sel
            assign word_sel[gi] = wr_en && (wr_idx == AW'(gi));
        end
    endgenerate

    always_comb begin
        fuse_d = fuse_q;
        wp_d   = wp_q;
        for (int w = 0; w < NWORDS; w++) begin
            if (word_sel[w]) begin
                fuse_d[w*WORD_WIDTH +: WORD_WIDTH] = wr_word;
                wp_d[w]                            = wr_flag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_RD;
            started_q   <= 1'b0;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            lc_q        <= 1'b0;
            retry_q     <= '0;
            pulse_cnt_q <= '0;
            rdata_q     <= '0;
            result_q    <= ST_OK;
            status_q    <= ST_OK;
            fuse_q      <= '0;
            wp_q        <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            lc_q        <= lc_d;
            retry_q     <= retry_d;
            pulse_cnt_q <= pulse_cnt_d;
            rdata_q     <= rdata_d;
            result_q    <= result_d;
            status_q    <= status_d;
            fuse_q      <= fuse_d;
            wp_q        <= wp_d;
        end
    end

    // Strobes decode straight from the state register, so the async reset of
    // state_q drops otp_pgm_en without waiting for a clock.
    assign prog_ready       = (state_q == IDLE) && init_done_q;
    assign prog_done        = (state_q == DONE);
    assign prog_status      = status_q;
    assign program_accepted = (state_q == PROGRAM) || (state_q == VERIFY_RD) ||
                              (state_q == VERIFY_WAIT) || (state_q == COMMIT);
    assign init_done        = init_done_q;
    assign fuse_value       = fuse_q;
    assign word_programmed  = wp_q;
    assign otp_pgm_en       = (state_q == PROGRAM);
    assign otp_rd_en        = ((state_q == INIT_RD) && started_q) || (state_q == VERIFY_RD);
    assign otp_addr         = ((state_q == INIT_RD) || (state_q == INIT_WAIT)) ? init_idx_q : addr_q;
    assign otp_wdata        = data_q;

endmodule

// File: tb/tb_otp_fuse_prog_ctrl.sv
// Self-checking bench for otp_fuse_prog_ctrl: behavioural fuse macro with random read
// latency, a vector table, multi-cycle corner sequences and randomized requests.
module tb_otp_fuse_prog_ctrl;

    localparam int PULSE = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         prog_req = 1'b0;
    logic         prog_ready;
    logic [2:0]   prog_addr = '0;
    logic [31:0]  prog_data = '0;
    logic         lifecycle_allows = 1'b0;
    logic         prog_done;
    logic [2:0]   prog_status;
    logic         program_accepted;
    logic         init_done;
    logic [255:0] fuse_value;
    logic [7:0]   word_programmed;
    logic         otp_pgm_en;
    logic [2:0]   otp_addr;
    logic [31:0]  otp_wdata;
    logic         otp_rd_en;
    logic [31:0]  otp_rdata = '0;
    logic         otp_rd_valid = 1'b0;

    always #5 clk = ~clk;

    otp_fuse_prog_ctrl #(
        .FUSE_WIDTH(256), .WORD_WIDTH(32), .PULSE_CYCLES(PULSE), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .prog_req(prog_req), .prog_ready(prog_ready), .prog_addr(prog_addr),
        .prog_data(prog_data), .lifecycle_allows(lifecycle_allows),
        .prog_done(prog_done), .prog_status(prog_status),
        .program_accepted(program_accepted), .init_done(init_done),
        .fuse_value(fuse_value), .word_programmed(word_programmed),
        .otp_pgm_en(otp_pgm_en), .otp_addr(otp_addr), .otp_wdata(otp_wdata),
        .otp_rd_en(otp_rd_en), .otp_rdata(otp_rdata), .otp_rd_valid(otp_rd_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fuse macro model: contents change only when a read follows a program pulse.
    logic [31:0] mem [8];
    logic [31:0] vq [$];
    logic [31:0] val = '0;
    logic [31:0] pgm_data = '0;
    logic [2:0]  rd_a = '0;
    bit          rd_pend = 0;
    bit          pgm_since = 0;
    int          rd_cnt = 0;
    int          rd_n = 0;

    always @(posedge clk) begin
        #1;
        otp_rd_valid = 1'b0;
        otp_rdata    = $urandom;
        if (rst) begin
            rd_pend   = 0;
            pgm_since = 0;
        end else begin
            if (rd_pend) begin
                if (rd_cnt <= 1) begin
                    if (pgm_since) begin
                        if (vq.size() > 0) val = vq.pop_front();
                        else val = mem[rd_a] | pgm_data;
                        mem[rd_a] = val;
                        pgm_since = 0;
                    end else begin
                        val = mem[rd_a];
                    end
                    otp_rd_valid = 1'b1;
                    otp_rdata    = val;
                    rd_pend      = 0;
                end else begin
                    rd_cnt--;
                end
            end
            if (otp_rd_en) begin
                rd_pend = 1;
                rd_cnt  = $urandom_range(1, 4);
                rd_a    = otp_addr;
                rd_n++;
            end
            if (otp_pgm_en) begin
                pgm_since = 1;
                pgm_data  = otp_wdata;
            end
        end
    end

    // Pulse, strobe-exclusivity and fuse-stability monitor.
    int           n_pulses = 0, first_start = -1, cur_len = 0, bad_len = 0;
    int           overlap = 0, stab_err = 0;
    bit           acc_seen = 0, pgm_prev = 0, acc_prev = 0, init_prev = 0;
    logic [255:0] fuse_prev = '0;

    always @(negedge clk) begin
        if (otp_pgm_en) begin
            if (!pgm_prev) begin
                n_pulses++;
                if (n_pulses == 1) first_start = cyc;
                cur_len = 0;
            end
            cur_len++;
        end else if (pgm_prev && cur_len != PULSE) begin
            bad_len++;
        end
        pgm_prev = otp_pgm_en;
        if (program_accepted) acc_seen = 1;
        if (otp_pgm_en && otp_rd_en) overlap++;
        if (otp_pgm_en && !program_accepted) overlap++;
        if (init_done && init_prev && fuse_value !== fuse_prev && !acc_prev) stab_err++;
        fuse_prev = fuse_value;
        acc_prev  = program_accepted;
        init_prev = init_done;
    end

    // Reference state: expected shadow words and non-blank flags.
    logic [31:0] exp_fuse [8];
    logic [7:0]  exp_wp;

    function automatic logic [255:0] pack_fuse();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = exp_fuse[i];
        return v;
    endfunction

    // Gating outcome before any pulse: 0 means the request goes on to program.
    function automatic int gate_status(input logic [2:0] a, input logic [31:0] d, input logic lc);
        if (!lc) return 1;
        if (exp_wp[a]) return 2;
        if (d == 32'h0) return 3;
        return 0;
    endfunction

    int t_acc = 0, done_lat = 0, got_st = 0;

    task automatic wait_init();
        int g = 0;
        while (!init_done && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("init_done_reached", 256'(init_done), 256'(1));
    endtask

    task automatic do_req(input logic [2:0] a, input logic [31:0] d, input logic lc);
        int g;
        @(negedge clk);
        g = 0;
        while (!prog_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("ready_before_req", 256'(prog_ready), 256'(1));
        n_pulses = 0; first_start = -1; bad_len = 0; acc_seen = 0;
        prog_req = 1'b1; prog_addr = a; prog_data = d; lifecycle_allows = lc;
        t_acc = cyc;
        @(negedge clk);
        prog_req = 1'b0; prog_addr = 3'($urandom); prog_data = $urandom;
        lifecycle_allows = 1'($urandom);
        g = 0;
        while (!prog_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", 256'(prog_done), 256'(1));
        done_lat = cyc - t_acc;
        got_st   = int'(prog_status);
        $display("req addr=%0d data=%08h lc=%0d -> status=%0d pulses=%0d latency=%0d",
                 a, d, lc, got_st, n_pulses, done_lat);
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [2:0] a, input int exp_st,
                                input int exp_p, input logic [31:0] exp_w);
        chk({tag, "_status"}, 256'(got_st), 256'(exp_st));
        chk({tag, "_pulses"}, 256'(n_pulses), 256'(exp_p));
        chk({tag, "_accepted"}, 256'(acc_seen), 256'(exp_p > 0));
        if (exp_p > 0) begin
            chk({tag, "_pulse_start"}, 256'(first_start), 256'(t_acc + 2));
            chk({tag, "_pulse_len"}, 256'(bad_len), 256'(0));
        end else begin
            chk({tag, "_reject_latency"}, 256'(done_lat), 256'(2));
        end
        chk({tag, "_word"}, 256'(fuse_value[int'(a)*32 +: 32]), 256'(exp_w));
        chk({tag, "_fuse"}, fuse_value, pack_fuse());
        chk({tag, "_wp"}, 256'(word_programmed), 256'(exp_wp));
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        lc;
        int          nrb;
        logic [31:0] rb0, rb1, rb2;
        int          exp_st;
        int          exp_p;
        logic [31:0] exp_w;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int g, d_cyc, exp_st, exp_p;
        logic [2:0]  ra;
        logic [31:0] rd, rb, exp_w;
        logic        rl;

        vecs[0] = '{3'd1, 32'hDEAD_BEEF, 1'b1, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF};
        vecs[1] = '{3'd3, 32'h1234_5678, 1'b1, 0, 0, 0, 0, 2, 0, 32'hA5A5_0000};
        vecs[2] = '{3'd3, 32'h1234_5678, 1'b0, 0, 0, 0, 0, 1, 0, 32'hA5A5_0000};
        vecs[3] = '{3'd2, 32'h0000_0000, 1'b1, 0, 0, 0, 0, 3, 0, 32'h0};
        vecs[4] = '{3'd2, 32'h0000_0000, 1'b0, 0, 0, 0, 0, 1, 0, 32'h0};
        vecs[5] = '{3'd4, 32'h0000_00FF, 1'b1, 3, 32'h0F, 32'h7F, 32'hFF, 0, 3, 32'hFF};
        vecs[6] = '{3'd5, 32'h0000_00FF, 1'b1, 3, 32'h0F, 32'h0F, 32'h0F, 4, 3, 32'h0F};
        vecs[7] = '{3'd1, 32'h0000_0001, 1'b1, 0, 0, 0, 0, 2, 0, 32'hDEAD_BEEF};
        vecs[8] = '{3'd5, 32'h0000_00FF, 1'b1, 0, 0, 0, 0, 2, 0, 32'h0F};

        for (int i = 0; i < 8; i++) begin
            mem[i]      = 32'h0;
            exp_fuse[i] = 32'h0;
        end
        mem[3]      = 32'hA5A5_0000;
        exp_fuse[3] = 32'hA5A5_0000;
        exp_wp      = 8'b0000_1000;

        // Reset state and initial shadow load.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_strobes", 256'({prog_ready, prog_done, program_accepted, init_done,
                                   otp_pgm_en, otp_rd_en, prog_status}), 256'(0));
        chk("reset_fuse", fuse_value, 256'(0));
        chk("reset_wp", 256'(word_programmed), 256'(0));
        chk("reset_macro_bus", 256'({otp_addr, otp_wdata}), 256'(0));
        rd_n = 0;
        rst  = 1'b0;
        @(negedge clk);
        chk("ready_low_during_init", 256'(prog_ready), 256'(0));
        wait_init();
        chk("init_read_count", 256'(rd_n), 256'(8));
        chk("init_wp", 256'(word_programmed), 256'(8'b0000_1000));
        chk("init_word3", 256'(fuse_value[127:96]), 256'(32'hA5A5_0000));
        chk("init_fuse", fuse_value, pack_fuse());
        chk("init_ready", 256'(prog_ready), 256'(1));

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].nrb > 0) vq.push_back(vecs[i].rb0);
            if (vecs[i].nrb > 1) vq.push_back(vecs[i].rb1);
            if (vecs[i].nrb > 2) vq.push_back(vecs[i].rb2);
            do_req(vecs[i].addr, vecs[i].data, vecs[i].lc);
            if (vecs[i].exp_p > 0) begin
                exp_fuse[vecs[i].addr] = vecs[i].exp_w;
                exp_wp[vecs[i].addr]   = 1'b1;
            end
            check_result($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_st,
                         vecs[i].exp_p, vecs[i].exp_w);
        end

        // Reset in cycle 50 of a pulse aborts it and reruns the shadow load.
        @(negedge clk);
        prog_req = 1'b1; prog_addr = 3'd0; prog_data = 32'h0000_00F0; lifecycle_allows = 1'b1;
        @(negedge clk);
        prog_req = 1'b0;
        g = 0;
        while (!otp_pgm_en && g < 20) begin
            @(negedge clk);
            g++;
        end
        repeat (49) @(negedge clk);
        chk("abort_pulse_active", 256'(otp_pgm_en), 256'(1));
        rst = 1'b1;
        #1;
        chk("abort_pgm_en_async", 256'(otp_pgm_en), 256'(0));
        chk("abort_accepted_clear", 256'(program_accepted), 256'(0));
        repeat (2) @(negedge clk);
        rd_n = 0;
        rst  = 1'b0;
        @(negedge clk);
        chk("abort_ready_low", 256'(prog_ready), 256'(0));
        wait_init();
        chk("abort_reinit_reads", 256'(rd_n), 256'(8));
        chk("abort_reinit_fuse", fuse_value, pack_fuse());
        chk("abort_reinit_wp", 256'(word_programmed), 256'(exp_wp));
        $display("reset mid-pulse: reinit reads=%0d wp=%02h", rd_n, word_programmed);

        // Request held high across CHECK/PROGRAM with a different address.
        @(negedge clk);
        g = 0;
        while (!prog_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        n_pulses = 0; first_start = -1; bad_len = 0;
        prog_req = 1'b1; prog_addr = 3'd7; prog_data = 32'h1; lifecycle_allows = 1'b1;
        t_acc = cyc;
        @(negedge clk);
        prog_addr = 3'd6; prog_data = 32'h2;
        g = 0;
        while (!prog_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("hold_first_done", 256'(prog_done), 256'(1));
        d_cyc = cyc;
        exp_fuse[7] = 32'h1;
        exp_wp[7]   = 1'b1;
        chk("hold_first_pulses", 256'(n_pulses), 256'(1));
        chk("hold_first_fuse", fuse_value, pack_fuse());
        $display("held req: first done at +%0d status=%0d", d_cyc - t_acc, prog_status);
        g = 0;
        @(negedge clk);
        while (!otp_pgm_en && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("hold_second_start", 256'(cyc), 256'(d_cyc + 3));
        prog_req = 1'b0;
        g = 0;
        while (!prog_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("hold_second_done", 256'(prog_done), 256'(1));
        chk("hold_second_status", 256'(prog_status), 256'(0));
        exp_fuse[6] = 32'h2;
        exp_wp[6]   = 1'b1;
        chk("hold_second_fuse", fuse_value, pack_fuse());
        chk("hold_second_wp", 256'(word_programmed), 256'(exp_wp));
        $display("held req: second pulse at done+%0d", cyc - d_cyc);

        // Randomized requests against the reference model.
        for (int r = 0; r < 16; r++) begin
            ra = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            rl = ($urandom_range(0, 3) != 0);
            exp_st = gate_status(ra, rd, rl);
            exp_p  = 0;
            exp_w  = exp_fuse[ra];
            if (exp_st == 0) begin
                exp_st = 4;
                for (int k = 0; k < 3; k++) begin
                    rb = ($urandom_range(0, 1) == 1) ? rd : (rd & $urandom);
                    vq.push_back(rb);
                    exp_p++;
                    exp_w = rb;
                    if (rb == rd) begin
                        exp_st = 0;
                        break;
                    end
                end
            end
            do_req(ra, rd, rl);
            if (exp_p > 0) begin
                exp_fuse[ra] = exp_w;
                exp_wp[ra]   = 1'b1;
            end
            check_result($sformatf("rnd%0d", r), ra, exp_st, exp_p, exp_w);
        end

        chk("strobe_exclusive", 256'(overlap), 256'(0));
        chk("fuse_stability", 256'(stab_err), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
